// File: rtl/out_port_arb_pkg.sv
// ----------------------------------------------------------------------------
// out_port_arb_pkg
//
// Purpose:
//   Shared definitions for the output-port arbiter slice: the two-state FSM
//   encoding and the helper that sizes port-select fields.
//
// Contents:
//   arb_state_e           - ST_EMPTY (output register free) / ST_FULL (dout_vld high)
//   port_sel_bits(n)      - width of an index selecting one of n ports (min 1)
//   DEFAULT_NUM_OUT_PORTS - port count used by the default configuration
//   PORT_SEL_BITS         - select width for the default port count
// ----------------------------------------------------------------------------
package out_port_arb_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;

    // A single port still needs a 1-bit index field so ports never collapse
    // to zero width.
    function automatic int port_sel_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEFAULT_NUM_OUT_PORTS = 7;
    localparam int PORT_SEL_BITS         = port_sel_bits(DEFAULT_NUM_OUT_PORTS);

endpackage : out_port_arb_pkg

// File: rtl/out_port_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//
// Purpose:
//   Purely combinational round-robin search. Starting one above last_i and
//   wrapping from N-1 to 0, returns the first asserted request. The port at
//   last_i itself is considered last (full wrap), so a lone requester is
//   always found.
//
// Parameters:
//   N - number of requesters
//   W - width of the index fields
//
// Ports:
//   req_i     [N-1:0] in  - request vector (1 = port has a packet)
//   last_i    [W-1:0] in  - index granted most recently
//   gnt_vld_o         out - at least one request is asserted
//   gnt_idx_o [W-1:0] out - chosen index (0 when gnt_vld_o is low)
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int N = 7,
    parameter int W = 3
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_i,
    output logic         gnt_vld_o,
    output logic [W-1:0] gnt_idx_o
);

    int         idx;
    logic [W-1:0] idx_w;

    // Walk offsets from the farthest down to the nearest so the nearest
    // match is the one left standing; this avoids an early loop exit.
    always_comb begin
        gnt_vld_o = 1'b0;
        gnt_idx_o = '0;
        idx       = 0;
        idx_w     = '0;
        for (int off = N; off >= 1; off--) begin
            idx = int'(last_i) + off;
            // last_i < N in normal operation; the second fold only keeps the
            // index in range if last_i ever holds an unused encoding.
            if (idx >= N) idx = idx - N;
            if (idx >= N) idx = idx - N;
            idx_w = W'(idx);
            if (req_i[idx_w]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = idx_w;
            end
        end
    end

endmodule : rr_pick

// File: rtl/out_port_arbiter.sv
// ----------------------------------------------------------------------------
// out_port_arbiter
//
// Purpose:
//   Arbitrates NUM_OUT_PORTS first-word-fall-through port FIFOs onto a single
//   registered network output. A two-state FSM tracks whether the output
//   register holds a packet. Whenever the register is free (or is being
//   emptied by a handshake this cycle) and stall is low, one non-empty port
//   is picked round-robin, popped combinationally via rd_en_sel and its head
//   packet loaded into dout. Back-to-back grants give one packet per cycle.
//
// Handshake:
//   dout/grant_id are valid while dout_vld is high; the network takes the
//   packet on a cycle where dout_vld and dout_rdy are both high. While
//   dout_vld is high and dout_rdy is low, dout and grant_id hold. rd_en_sel
//   is a one-hot-or-zero pop strobe, asserted only in the cycle the port is
//   granted and only for a port whose empty bit is low. stall blocks new
//   grants but never blocks a pending handshake.
//
// Build option:
//   OUT_PORT_ARB_BURST_EN - when defined, the last granted port keeps the
//   grant while non-empty for up to BURST_LEN consecutive grants before the
//   round-robin rotation resumes. When undefined, every grant rotates and
//   BURST_LEN has no effect.
//
// Ports:
//   clk                                      in  - clock
//   reset                                    in  - synchronous, active high
//   empty        [NUM_OUT_PORTS-1:0]         in  - per-port FIFO empty
//   internal_out [PACKET_BITS*NUM_OUT_PORTS-1:0] in - per-port head packets
//   rd_en_sel    [NUM_OUT_PORTS-1:0]         out - pop strobe (one-hot or zero)
//   stall                                    in  - blocks new grants
//   dout         [PACKET_BITS-1:0]           out - registered packet
//   dout_vld                                 out - dout valid
//   dout_rdy                                 in  - network ready
//   grant_id     [clog2(NUM_OUT_PORTS)-1:0]  out - source port of dout
//   state_o                                  out - FSM state (observability)
// ----------------------------------------------------------------------------
module out_port_arbiter
    import out_port_arb_pkg::*;
#(
    parameter int PACKET_BITS   = 97,
    parameter int NUM_OUT_PORTS = 7,
    parameter int BURST_LEN     = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_OUT_PORTS-1:0]              empty,
    input  logic [PACKET_BITS*NUM_OUT_PORTS-1:0]  internal_out,
    output logic [NUM_OUT_PORTS-1:0]              rd_en_sel,
    input  logic                                  stall,
    output logic [PACKET_BITS-1:0]                dout,
    output logic                                  dout_vld,
    input  logic                                  dout_rdy,
    output logic [port_sel_bits(NUM_OUT_PORTS)-1:0] grant_id,
    output arb_state_e                            state_o
);

    localparam int SEL_W = port_sel_bits(NUM_OUT_PORTS);
    localparam logic [SEL_W-1:0] LAST_PORT = SEL_W'(NUM_OUT_PORTS - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    arb_state_e             state_q;
    logic [PACKET_BITS-1:0] dout_q;
    logic                   dout_vld_q;
    logic [SEL_W-1:0]       grant_id_q;
    logic [SEL_W-1:0]       last_q;

    // ------------------------------------------------------------------
    // Round-robin search over the non-empty ports
    // ------------------------------------------------------------------
    logic [NUM_OUT_PORTS-1:0] req;
    logic                     rr_vld;
    logic [SEL_W-1:0]         rr_idx;

    assign req = ~empty;

    rr_pick #(
        .N (NUM_OUT_PORTS),
        .W (SEL_W)
    ) u_rr_pick (
        .req_i     (req),
        .last_i    (last_q),
        .gnt_vld_o (rr_vld),
        .gnt_idx_o (rr_idx)
    );

    logic             pick_vld;
    logic [SEL_W-1:0] pick_idx;

`ifdef OUT_PORT_ARB_BURST_EN
    // The counter reaches at most BURST_LEN-1.
    localparam int CNT_W = port_sel_bits(BURST_LEN);

    logic [CNT_W-1:0] burst_cnt_q;
    // Set by the first grant after reset: until then last_q is only a
    // search start point, not a port that owns a burst.
    logic             burst_live_q;
    logic             repeat_ok;

    assign repeat_ok = burst_live_q && req[last_q] &&
                       (int'(burst_cnt_q) < BURST_LEN - 1);
    assign pick_vld  = repeat_ok || rr_vld;
    assign pick_idx  = repeat_ok ? last_q : rr_idx;
`else
    // BURST_LEN has no effect in this build.
    logic unused_burst_len;
    assign unused_burst_len = (BURST_LEN != 0);

    assign pick_vld = rr_vld;
    assign pick_idx = rr_idx;
`endif

    // ------------------------------------------------------------------
    // Grant decision
    // ------------------------------------------------------------------
    // The output register can take a packet when it is free, or when the
    // packet it holds leaves this very cycle.
    logic load_ok;
    logic grant;

    assign load_ok = (state_q == ST_EMPTY) || (dout_vld_q && dout_rdy);
    assign grant   = !reset && load_ok && !stall && pick_vld;

    // pick_vld only rises for a port whose request (empty low) is set, so
    // the pop can never target an empty FIFO.
    always_comb begin
        rd_en_sel = '0;
        if (grant) begin
            rd_en_sel[pick_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // A packet held here is dropped without a pop.
            state_q      <= ST_EMPTY;
            dout_q       <= '0;
            dout_vld_q   <= 1'b0;
            grant_id_q   <= '0;
            last_q       <= LAST_PORT;
`ifdef OUT_PORT_ARB_BURST_EN
            burst_cnt_q  <= '0;
            burst_live_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (grant) begin
                        state_q    <= ST_FULL;
                        dout_vld_q <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (grant) begin
                        state_q    <= ST_FULL;
                        dout_vld_q <= 1'b1;
                    end else if (dout_vld_q && dout_rdy) begin
                        state_q    <= ST_EMPTY;
                        dout_vld_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_EMPTY;
                    dout_vld_q <= 1'b0;
                end
            endcase

            if (grant) begin
                dout_q     <= internal_out[int'(pick_idx)*PACKET_BITS +: PACKET_BITS];
                grant_id_q <= pick_idx;
                last_q     <= pick_idx;
`ifdef OUT_PORT_ARB_BURST_EN
                burst_live_q <= 1'b1;
                // Repeats extend the burst; any rotation starts a new one.
                if (repeat_ok) begin
                    burst_cnt_q <= burst_cnt_q + 1'b1;
                end else begin
                    burst_cnt_q <= '0;
                end
`endif
            end
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign grant_id = grant_id_q;
    assign state_o  = state_q;

endmodule : out_port_arbiter

// File: tb/tb_out_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_out_port_arbiter
//
// Bench for out_port_arbiter. Port FIFOs are modelled as a packet count plus
// a head packet per port. A reference model predicts each cycle's grant from
// the arbitration rules (modular search from the last grant, optional burst
// continuation) and a scoreboard queue holds the packet expected on dout.
// Directed sequences cover reset, single grant, full rotation, back-pressure,
// stall, burst and mid-transfer reset; a randomized phase follows.
// Define OUT_PORT_ARB_BURST_EN for both bench and RTL to exercise bursts.
// ----------------------------------------------------------------------------
module tb_out_port_arbiter;
    import out_port_arb_pkg::*;

    localparam int PB = 97;
    localparam int N  = 7;
    localparam int BL = 4;
    localparam int GW = PORT_SEL_BITS;
    localparam int SW = PB + GW;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      empty;
    logic [PB*N-1:0]   internal_out;
    logic [N-1:0]      rd_en_sel;
    logic              stall;
    logic [PB-1:0]     dout;
    logic              dout_vld;
    logic              dout_rdy;
    logic [GW-1:0]     grant_id;
    arb_state_e        state_o;

    always #5 clk = ~clk;

    out_port_arbiter #(
        .PACKET_BITS   (PB),
        .NUM_OUT_PORTS (N),
        .BURST_LEN     (BL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .empty        (empty),
        .internal_out (internal_out),
        .rd_en_sel    (rd_en_sel),
        .stall        (stall),
        .dout         (dout),
        .dout_vld     (dout_vld),
        .dout_rdy     (dout_rdy),
        .grant_id     (grant_id),
        .state_o      (state_o)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // ------------------------------------------------------------------
    // Port FIFO model and reference model
    // ------------------------------------------------------------------
    int            cnt [N];
    logic [PB-1:0] head[N];

    bit m_vld;
    int m_last;
    int m_cnt;
    bit m_live;

    logic [SW-1:0] exp_q[$];

    function automatic logic [PB-1:0] new_pkt();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[PB-1:0];
    endfunction

    task automatic drive_ports();
        for (int i = 0; i < N; i++) begin
            empty[i] = (cnt[i] == 0);
            internal_out[i*PB +: PB] = (cnt[i] == 0) ? '0 : head[i];
        end
    endtask

    task automatic set_all_cnt(input int v);
        for (int i = 0; i < N; i++) cnt[i] = v;
    endtask

    // Which port the rules say gets the next grant, ignoring load/stall.
    task automatic model_pick(output bit v, output int g, output bit rep);
        v = 1'b0;
        g = 0;
        rep = 1'b0;
`ifdef OUT_PORT_ARB_BURST_EN
        if (m_live && cnt[m_last] > 0 && m_cnt < BL - 1) begin
            v = 1'b1;
            g = m_last;
            rep = 1'b1;
        end
`endif
        for (int k = 1; k <= N; k++) begin
            if (!v && cnt[(m_last + k) % N] > 0) begin
                v = 1'b1;
                g = (m_last + k) % N;
            end
        end
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model.
    task automatic cycle_step(input bit rdy, input bit stl, output logic [N-1:0] sel_seen);
        bit            v;
        bit            rep;
        bit            gnt;
        int            g;
        logic [N-1:0]  exp_sel;
        logic [SW-1:0] front;
        dout_rdy = rdy;
        stall    = stl;
        drive_ports();
        @(negedge clk);
        model_pick(v, g, rep);
        gnt = (!m_vld || rdy) && !stl && v;
        exp_sel = '0;
        if (gnt) exp_sel[g] = 1'b1;
        sel_seen = rd_en_sel;
        check("rd_en_sel", rd_en_sel, exp_sel);
        check("dout_vld", dout_vld, m_vld);
        if (m_vld) begin
            if (exp_q.size() == 0) begin
                check("sb_depth", exp_q.size(), 1);
            end else begin
                front = exp_q[0];
                check("dout", dout, front[PB-1:0]);
                check("grant_id", grant_id, front[SW-1:PB]);
            end
        end
        if (m_vld && rdy) begin
            void'(exp_q.pop_front());
            m_vld = 1'b0;
        end
        if (gnt) begin
            exp_q.push_back({GW'(g), head[g]});
            cnt[g]--;
            head[g] = new_pkt();
            m_cnt  = rep ? m_cnt + 1 : 0;
            m_last = g;
            m_live = 1'b1;
            m_vld  = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        dout_rdy = 1'b0;
        stall    = 1'b0;
        drive_ports();
        @(negedge clk);
        check("rst_rd_en_sel", rd_en_sel, '0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        m_vld  = 1'b0;
        m_last = N - 1;
        m_cnt  = 0;
        m_live = 1'b0;
        exp_q.delete();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [N-1:0]  sel;
        logic [PB-1:0] hold_dout;
        logic [GW-1:0] hold_gid;
        int            exp_rot[8];
        int            exp_burst[9];

        exp_rot   = '{0, 1, 2, 3, 4, 5, 6, 0};
        exp_burst = '{2, 2, 2, 2, 5, 5, 5, 5, 2};

        reset = 1'b1;
        stall = 1'b0;
        dout_rdy = 1'b0;
        for (int i = 0; i < N; i++) head[i] = new_pkt();
        set_all_cnt(0);
        drive_ports();
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        do_reset();
        check("rst_dout_vld", dout_vld, 1'b0);
        check("rst_dout", dout, '0);
        check("rst_grant_id", grant_id, '0);
        check("rst_state", state_o, ST_EMPTY);

        // Only port 0 holds a packet
        cnt[0] = 1;
        cycle_step(1'b1, 1'b0, sel);
        check("single_sel", sel, 7'b0000001);
        check("single_vld", dout_vld, 1'b1);
        check("single_gid", grant_id, 0);
        check("single_state", state_o, ST_FULL);
        cycle_step(1'b1, 1'b0, sel);
        check("single_drained", dout_vld, 1'b0);

        // All ports busy, ready held high: one packet per cycle
        do_reset();
        set_all_cnt(100);
        for (int i = 0; i < 8; i++) begin
            cycle_step(1'b1, 1'b0, sel);
            check("rate_vld", dout_vld, 1'b1);
`ifndef OUT_PORT_ARB_BURST_EN
            check("rot_seq", grant_id, exp_rot[i]);
`endif
        end

        // Back-pressure: held packet must not move, no pops
        hold_dout = dout;
        hold_gid  = grant_id;
        for (int i = 0; i < 5; i++) begin
            cycle_step(1'b0, 1'b0, sel);
            check("bp_sel", sel, '0);
            check("bp_dout", dout, hold_dout);
            check("bp_gid", grant_id, hold_gid);
        end
        cycle_step(1'b1, 1'b0, sel);
        check("bp_regrant", (sel != '0), 1'b1);

        // Stall drains the held packet but issues no new grant
        cycle_step(1'b1, 1'b1, sel);
        check("stall_sel", sel, '0);
        check("stall_vld", dout_vld, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cycle_step(1'b1, 1'b1, sel);
            check("stall_idle_sel", sel, '0);
        end
        cycle_step(1'b1, 1'b0, sel);
        check("unstall_grant", (sel != '0), 1'b1);
        check("unstall_vld", dout_vld, 1'b1);

`ifdef OUT_PORT_ARB_BURST_EN
        // Burst of BL grants per port across ports 2 and 5
        do_reset();
        set_all_cnt(0);
        cnt[2] = 100;
        cnt[5] = 100;
        for (int i = 0; i < 9; i++) begin
            cycle_step(1'b1, 1'b0, sel);
            check("burst_seq", grant_id, exp_burst[i]);
        end
`endif

        // Reset in the middle of a transfer
        do_reset();
        set_all_cnt(100);
        for (int i = 0; i < 3; i++) cycle_step(1'b1, 1'b0, sel);
        check("mid_pre_vld", dout_vld, 1'b1);
        do_reset();
        check("mid_rst_vld", dout_vld, 1'b0);
        cycle_step(1'b1, 1'b0, sel);
        check("mid_rst_restart", sel, 7'b0000001);
        check("mid_rst_gid", grant_id, 0);

        // Randomized traffic
        do_reset();
        set_all_cnt(0);
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0 && cnt[i] < 8) cnt[i] += $urandom_range(1, 3);
            end
            cycle_step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, sel);
        end

        // Let the last packet out
        for (int i = 0; i < 3; i++) cycle_step(1'b1, 1'b1, sel);
        check("final_sb_depth", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_out_port_arbiter

// File: doc/out_port_arbiter.md
OUT_PORT_ARBITER -- requirements
Module: out_port_arbiter

Interface
REQ-001 SHALL have parameter PACKET_BITS, default 97, width of one packet.
REQ-002 SHALL have parameter NUM_OUT_PORTS, default 7, number of arbitrated output ports.
REQ-003 SHALL have parameter BURST_LEN, default 4, maximum consecutive grants to one port; used only when burst mode is compiled in.
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port empty, input, NUM_OUT_PORTS, per-port FIFO empty; low means that port's internal_out slice holds a valid first-word-fall-through packet.
REQ-007 SHALL have port internal_out, input, PACKET_BITS*NUM_OUT_PORTS, per-port packet head; port i occupies bits [PACKET_BITS*(i+1)-1 : PACKET_BITS*i].
REQ-008 SHALL have port rd_en_sel, output, NUM_OUT_PORTS, one-hot-or-zero pop strobe to port FIFOs.
REQ-009 SHALL have port stall, input, 1, blocks new grants while high.
REQ-010 SHALL have port dout, output, PACKET_BITS, registered packet to network.
REQ-011 SHALL have port dout_vld, output, 1, dout valid.
REQ-012 SHALL have port dout_rdy, input, 1, network accepts dout when dout_vld and dout_rdy are both high.
REQ-013 SHALL have port grant_id, output, clog2(NUM_OUT_PORTS), index of the port that sourced the current dout.

Function
REQ-014 SHALL implement a two-state FSM: EMPTY (output register free) and FULL (dout_vld high).
REQ-015 SHALL define load_ok = (state==EMPTY) or (dout_vld and dout_rdy).
REQ-016 SHALL evaluate a grant in the same cycle when load_ok and not stall and any empty bit is low.
REQ-017 SHALL select the grant round-robin: the first non-empty port searched upward from last_grant+1, wrapping from NUM_OUT_PORTS-1 to 0.
REQ-018 SHALL, on a grant, assert rd_en_sel[g] combinationally for exactly that cycle; rd_en_sel SHALL be zero otherwise.
REQ-019 SHALL, on a grant, load internal_out slice g into dout, g into grant_id and last_grant, set dout_vld, and move to FULL on the next edge.
REQ-020 SHALL, on a handshake with no new grant, clear dout_vld and move to EMPTY.
REQ-021 SHALL, on a handshake with a simultaneous grant, stay in FULL with the new packet, giving one packet per cycle throughput.
REQ-022 SHALL hold dout and grant_id stable while dout_vld is high and dout_rdy is low.
REQ-023 SHALL let stall block grants only; a held packet SHALL still complete its handshake while stall is high.
REQ-024 SHALL never assert rd_en_sel for a port whose empty bit is high.

Reset
REQ-025 SHALL, on synchronous reset, set state=EMPTY, dout_vld=0, dout=0, grant_id=0, last_grant=NUM_OUT_PORTS-1 (so port 0 is searched first), burst counter=0, rd_en_sel=0.
REQ-026 SHALL, when reset is asserted mid-transfer, discard the held packet with no pop issued; this loss is accepted.

Configuration
REQ-027 SHALL provide macro OUT_PORT_ARB_BURST_EN.
REQ-028 SHALL, with the macro defined, keep granting last_grant while it is non-empty and the burst counter is below BURST_LEN-1, and otherwise rotate per REQ-017; the counter increments on each repeated grant and clears on a rotation.
REQ-029 SHALL, without the macro, rotate on every grant, omit the burst counter entirely, and ignore BURST_LEN.

Structure
REQ-030 SHALL place the FSM state enum and the PORT_SEL_BITS helper constant in shared package out_port_arb_pkg.
REQ-031 SHALL implement the rotate-and-search logic as sub-module rr_pick: inputs are the request vector and last index; outputs are grant valid and grant index; it is purely combinational.

Verification
REQ-032 SHALL test: after reset, empty=7'b1111110 and dout_rdy=1 -> rd_en_sel=7'b0000001 in cycle 0; dout_vld=1 and grant_id=0 in cycle 1.
REQ-033 SHALL test: all ports non-empty, dout_rdy held 1, macro off -> grant_id sequence 0,1,2,3,4,5,6,0 with one packet per cycle.
REQ-034 SHALL test: dout_rdy=0 for 5 cycles with a packet held -> dout and grant_id unchanged and rd_en_sel=0 throughout; dout_rdy=1 -> handshake, then next grant.
REQ-035 SHALL test: stall=1 with a packet held and dout_rdy=1 -> the packet drains, dout_vld drops, and no rd_en_sel occurs until stall=0.
REQ-036 SHALL test: macro on, BURST_LEN=4, ports 2 and 5 non-empty -> grant_id 2,2,2,2,5,5,5,5,2.
REQ-037 SHALL test: reset pulsed while dout_vld=1 -> the next cycle shows dout_vld=0, rd_en_sel=0, and the following grant starts the search at port 0.
